// File: rtl/alu_writeback_stage.sv
// ALU write-back stage: reads two operands from a 4x4 register file, executes one
// operation (MUL as a 4-cycle shift-add) and writes the result back with a one-cycle
// write enable. One operation is in flight at a time.
module alu_writeback_stage (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic [2:0] opcode,
  input  logic [1:0] src_a,
  input  logic [1:0] src_b,
  input  logic [1:0] dst,
  output logic [1:0] rs,
  output logic [1:0] rt,
  input  logic [3:0] crs,
  input  logic [3:0] crt,
  output logic [3:0] dw,
  output logic [1:0] rw,
  output logic       rwe,
  output logic       carry,
  output logic       zero,
  output logic       busy
);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpOr  = 3'b011;
  localparam logic [2:0] OpXor = 3'b100;
  localparam logic [2:0] OpMul = 3'b101;
  localparam logic [2:0] OpShl = 3'b110;
  localparam logic [2:0] OpNop = 3'b111;

  typedef enum logic [1:0] {StIdle, StRead, StExec, StWb} state_e;

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [1:0]  dst_q, dst_d;
  logic [1:0]  rs_q, rs_d;
  logic [1:0]  rt_q, rt_d;
  logic [3:0]  opa_q, opa_d;
  logic [3:0]  opb_q, opb_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  prod_q, prod_d;
  logic [3:0]  dw_q, dw_d;
  logic [1:0]  rw_q, rw_d;
  logic        rwe_q, rwe_d;
  logic        carry_q, carry_d;
  logic        zero_q, zero_d;
  logic        busy_q, busy_d;

  logic [4:0]  sum5;
  logic [7:0]  shl8;
  logic [7:0]  partial;
  logic [7:0]  prod_sum;
  logic [3:0]  alu_res;
  logic        alu_c;

  assign sum5     = {1'b0, opa_q} + {1'b0, opb_q};
  assign shl8     = {4'b0000, opa_q} << opb_q[1:0];
  // One shift-add step: add opA weighted by the multiplier bit selected by the counter.
  assign partial  = opb_q[cnt_q] ? ({4'b0000, opa_q} << cnt_q) : 8'd0;
  assign prod_sum = prod_q + partial;

  // Single-cycle ALU result and carry for the latched opcode.
  always_comb begin
    alu_res = 4'd0;
    alu_c   = 1'b0;
    case (op_q)
      OpAdd: {alu_c, alu_res} = sum5;
      OpSub: begin
        alu_res = opa_q - opb_q;
        alu_c   = (opa_q < opb_q);
      end
      OpAnd: alu_res = opa_q & opb_q;
      OpOr:  alu_res = opa_q | opb_q;
      OpXor: alu_res = opa_q ^ opb_q;
      OpShl: begin
        alu_res = shl8[3:0];
        alu_c   = |shl8[7:4];
      end
      default: ;
    endcase
  end

  // Next-state and next-output logic for the IDLE/READ/EXEC/WB sequence.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    dst_d   = dst_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    dw_d    = dw_q;
    rw_d    = rw_q;
    rwe_d   = 1'b0;
    carry_d = carry_q;
    zero_d  = zero_q;

    case (state_q)
      StIdle: begin
        if (op_valid) begin
          op_d    = opcode;
          dst_d   = dst;
          rs_d    = src_a;
          rt_d    = src_b;
          state_d = StRead;
        end
      end
      StRead: begin
        opa_d   = crs;
        opb_d   = crt;
        cnt_d   = 2'd0;
        prod_d  = 8'd0;
        state_d = StExec;
      end
      StExec: begin
        if (op_q == OpNop) begin
          state_d = StIdle;
        end else if (op_q == OpMul) begin
          prod_d = prod_sum;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = StWb;
            rwe_d   = 1'b1;
            dw_d    = prod_sum[3:0];
            rw_d    = dst_q;
            carry_d = (prod_sum > 8'd15);
            zero_d  = (prod_sum[3:0] == 4'd0);
          end
        end else begin
          state_d = StWb;
          rwe_d   = 1'b1;
          dw_d    = alu_res;
          rw_d    = dst_q;
          carry_d = alu_c;
          zero_d  = (alu_res == 4'd0);
        end
      end
      StWb: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  // State and registered outputs; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= 3'd0;
      dst_q   <= 2'd0;
      rs_q    <= 2'd0;
      rt_q    <= 2'd0;
      opa_q   <= 4'd0;
      opb_q   <= 4'd0;
      cnt_q   <= 2'd0;
      prod_q  <= 8'd0;
      dw_q    <= 4'd0;
      rw_q    <= 2'd0;
      rwe_q   <= 1'b0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dst_q   <= dst_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      dw_q    <= dw_d;
      rw_q    <= rw_d;
      rwe_q   <= rwe_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
    end
  end

  assign op_ready = (state_q == StIdle);
  assign rs       = rs_q;
  assign rt       = rt_q;
  assign dw       = dw_q;
  assign rw       = rw_q;
  assign rwe      = rwe_q;
  assign carry    = carry_q;
  assign zero     = zero_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Bench for alu_writeback_stage: behavioural 4x4 register file, directed operations with
// hand-computed results pushed to a scoreboard, and a monitor that checks every rwe pulse.
module tb_alu_writeback_stage;

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpOr  = 3'b011;
  localparam logic [2:0] OpXor = 3'b100;
  localparam logic [2:0] OpMul = 3'b101;
  localparam logic [2:0] OpShl = 3'b110;
  localparam logic [2:0] OpNop = 3'b111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       op_valid;
  logic       op_ready;
  logic [2:0] opcode;
  logic [1:0] src_a, src_b, dst;
  logic [1:0] rs, rt;
  logic [3:0] crs, crt;
  logic [3:0] dw;
  logic [1:0] rw;
  logic       rwe, carry, zero, busy;

  typedef struct {
    logic [3:0] dw;
    logic [1:0] rw;
    logic       c;
    logic       z;
    int         lat;
    int         acc;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;

  logic [3:0] rf [4] = '{default: 4'd0};
  logic       pl_en = 1'b0;
  logic [1:0] pl_idx = 2'd0;
  logic [3:0] pl_val = 4'd0;

  always #5 clk = ~clk;

  alu_writeback_stage dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .opcode   (opcode),
    .src_a    (src_a),
    .src_b    (src_b),
    .dst      (dst),
    .rs       (rs),
    .rt       (rt),
    .crs      (crs),
    .crt      (crt),
    .dw       (dw),
    .rw       (rw),
    .rwe      (rwe),
    .carry    (carry),
    .zero     (zero),
    .busy     (busy)
  );

  assign crs = rf[rs];
  assign crt = rf[rt];

  // Register file: DUT write-back has priority over bench preloads.
  always @(posedge clk) begin
    if (rwe) rf[rw] <= dw;
    else if (pl_en) rf[pl_idx] <= pl_val;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write-back pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && rwe) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_rwe: got rw=%0d dw=%0d, expected no write", rw, dw);
      end else begin
        mon_e = sb.pop_front();
        check("wb_dw", dw, mon_e.dw);
        check("wb_rw", rw, mon_e.rw);
        check("wb_carry", carry, mon_e.c);
        check("wb_zero", zero, mon_e.z);
        check("wb_latency", cyc - mon_e.acc, mon_e.lat);
      end
    end
  end

  task automatic preload(input logic [1:0] idx, input logic [3:0] val);
    pl_idx = idx;
    pl_val = val;
    pl_en  = 1'b1;
    @(posedge clk);
    #1;
    pl_en  = 1'b0;
  endtask

  task automatic push_exp(input logic [3:0] edw, input logic [1:0] erw, input logic ec,
                          input logic ez, input int lat, input int acc);
    exp_t e;
    e.dw  = edw;
    e.rw  = erw;
    e.c   = ec;
    e.z   = ez;
    e.lat = lat;
    e.acc = acc;
    sb.push_back(e);
  endtask

  // lat counts clock edges from the accept edge to the edge that raises rwe.
  task automatic issue(input logic [2:0] op, input logic [1:0] a, input logic [1:0] b,
                       input logic [1:0] d, input logic [3:0] edw, input logic ec,
                       input logic ez, input int lat, input bit push);
    int n = 0;
    while (!op_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!op_ready) begin
      check("issue_ready_timeout", op_ready, 1);
      return;
    end
    op_valid = 1'b1;
    opcode   = op;
    src_a    = a;
    src_b    = b;
    dst      = d;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    // Scramble the request fields; the latched operation must not see this.
    opcode   = ~op;
    src_a    = ~a;
    src_b    = ~b;
    dst      = ~d;
    check("accept_busy", busy, 1);
    if (push) push_exp(edw, d, ec, ez, lat, cyc);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || !op_ready) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", (sb.size() == 0 && op_ready) ? 1 : 0, 1);
  endtask

  task automatic busy_len(input string name, input int exp);
    int n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) n++;
      else break;
    end
    check(name, n, exp);
    check("ready_after_op", op_ready, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rs"}, rs, 0);
    check({tag, "_rt"}, rt, 0);
    check({tag, "_dw"}, dw, 0);
    check({tag, "_rw"}, rw, 0);
    check({tag, "_rwe"}, rwe, 0);
    check({tag, "_carry"}, carry, 0);
    check({tag, "_zero"}, zero, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_op_ready"}, op_ready, 1);
  endtask

  initial begin
    int  acc_cnt;
    int  acc_cyc[$];
    bit  rdy;

    rst_n    = 1'b0;
    op_valid = 1'b0;
    opcode   = OpNop;
    src_a    = 2'd0;
    src_b    = 2'd0;
    dst      = 2'd0;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ADD 7+9 = 16: result 0 with carry and zero, overwrites r3.
    preload(2'd1, 4'd7);
    preload(2'd2, 4'd9);
    preload(2'd3, 4'd5);
    issue(OpAdd, 2'd1, 2'd2, 2'd3, 4'd0, 1'b1, 1'b1, 2, 1'b1);
    busy_len("busy_len_add", 3);
    wait_idle();
    check("rf3_after_add", rf[3], 0);

    // SUB 3-5 = 14 with borrow into r0, then 14-5 = 9 reading the written r0.
    preload(2'd0, 4'd3);
    preload(2'd1, 4'd5);
    issue(OpSub, 2'd0, 2'd1, 2'd0, 4'd14, 1'b1, 1'b0, 2, 1'b1);
    wait_idle();
    check("rf0_after_sub", rf[0], 14);
    issue(OpSub, 2'd0, 2'd1, 2'd2, 4'd9, 1'b0, 1'b0, 2, 1'b1);
    wait_idle();

    // Bitwise ops on 12 and 10; XOR of a register with itself into itself gives zero.
    preload(2'd0, 4'd12);
    preload(2'd1, 4'd10);
    issue(OpAnd, 2'd0, 2'd1, 2'd2, 4'd8, 1'b0, 1'b0, 2, 1'b1);
    wait_idle();
    issue(OpOr, 2'd0, 2'd1, 2'd2, 4'd14, 1'b0, 1'b0, 2, 1'b1);
    wait_idle();
    issue(OpXor, 2'd0, 2'd1, 2'd2, 4'd6, 1'b0, 1'b0, 2, 1'b1);
    wait_idle();
    issue(OpXor, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0, 1'b1, 2, 1'b1);
    wait_idle();

    // MUL 6*3 = 18 -> 2 with overflow; MUL 3*5 = 15 without.
    preload(2'd2, 4'd6);
    preload(2'd3, 4'd3);
    issue(OpMul, 2'd2, 2'd3, 2'd1, 4'd2, 1'b1, 1'b0, 5, 1'b1);
    busy_len("busy_len_mul", 6);
    wait_idle();
    preload(2'd0, 4'd5);
    issue(OpMul, 2'd3, 2'd0, 2'd2, 4'd15, 1'b0, 1'b0, 5, 1'b1);
    wait_idle();

    // SHL 9<<1 loses the top bit; 9<<0 is unchanged.
    preload(2'd1, 4'd9);
    preload(2'd2, 4'd1);
    issue(OpShl, 2'd1, 2'd2, 2'd3, 4'd2, 1'b1, 1'b0, 2, 1'b1);
    wait_idle();
    preload(2'd2, 4'd0);
    issue(OpShl, 2'd1, 2'd2, 2'd3, 4'd9, 1'b0, 1'b0, 2, 1'b1);
    wait_idle();

    // NOP after an ADD that sets both flags: no write, flags held.
    preload(2'd1, 4'd7);
    preload(2'd2, 4'd9);
    issue(OpAdd, 2'd1, 2'd2, 2'd3, 4'd0, 1'b1, 1'b1, 2, 1'b1);
    wait_idle();
    issue(OpNop, 2'd1, 2'd2, 2'd0, 4'd0, 1'b0, 1'b0, 0, 1'b0);
    busy_len("busy_len_nop", 2);
    check("nop_carry_held", carry, 1);
    check("nop_zero_held", zero, 1);
    check("nop_rf0_untouched", rf[0], 5);

    // op_valid held high for 12 edges: accepts on edges 1, 5 and 9 only.
    preload(2'd0, 4'd1);
    preload(2'd1, 4'd2);
    op_valid = 1'b1;
    opcode   = OpAdd;
    src_a    = 2'd0;
    src_b    = 2'd1;
    dst      = 2'd2;
    acc_cnt  = 0;
    for (int i = 0; i < 12; i++) begin
      rdy = op_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        acc_cnt++;
        acc_cyc.push_back(cyc);
        push_exp(4'd3, 2'd2, 1'b0, 1'b0, 2, cyc);
      end
    end
    op_valid = 1'b0;
    check("held_valid_accepts", acc_cnt, 3);
    if (acc_cyc.size() >= 2) check("accept_spacing", acc_cyc[1] - acc_cyc[0], 4);
    wait_idle();

    // Reset in the third MUL EXEC cycle aborts it; ADD on the first edge after release.
    preload(2'd2, 4'd6);
    preload(2'd3, 4'd3);
    issue(OpMul, 2'd2, 2'd3, 2'd1, 4'd0, 1'b0, 1'b0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midop_reset");
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    op_valid = 1'b1;
    opcode   = OpAdd;
    src_a    = 2'd0;
    src_b    = 2'd1;
    dst      = 2'd3;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    check("accept_after_reset", busy, 1);
    push_exp(4'd3, 2'd3, 1'b0, 1'b0, 2, cyc);
    wait_idle();
    check("aborted_mul_no_write", rf[1], 2);
    check("rf3_after_reset_add", rf[3], 3);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
